// File: rtl/esc_pwm_generator_pkg.sv
// Shared constants, FSM encoding and pulse-width helper for the ESC pulse generator.
package esc_pwm_generator_pkg;

    localparam int REC_VAL_BIT_WIDTH   = 8;
    localparam int ESC_FRAME_PERIOD_US = 2500;
    localparam int ESC_MIN_PULSE_US    = 1000;
    localparam int ESC_PULSE_SCALE     = 4;
    localparam int ESC_MAX_VALUE       = 250;
    localparam int ESC_WATCHDOG_FRAMES = 8;

    typedef enum logic [2:0] {
        STATE_DISARMED   = 3'b001,
        STATE_PULSE_HIGH = 3'b010,
        STATE_PULSE_LOW  = 3'b100
    } esc_state_e;

    // Max result is 1000 + 4*250 = 2000, well inside 12 bits.
    function automatic logic [11:0] pulse_width(input logic [REC_VAL_BIT_WIDTH-1:0] v,
                                                input int min_us, input int scale);
        pulse_width = 12'(min_us) + 12'(scale) * 12'(v);
    endfunction

endpackage

// File: rtl/esc_pwm_generator_frame_timer.sv
// 12-bit frame counter: clear wins over enable, wraps at PERIOD-1; start/tc strobes are combinational.
// No backpressure; counts every enabled cycle.
module esc_pwm_generator_frame_timer #(
    parameter int PERIOD = 2500
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [11:0] cnt_o,
    output logic        start_o,
    output logic        tc_o
);

    logic [11:0] cnt_q, cnt_d;

    assign tc_o    = (cnt_q == 12'(PERIOD - 1));
    assign start_o = en_i && (cnt_q == 12'd0);
    assign cnt_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 12'd0;
        end else if (en_i) begin
            cnt_d = tc_o ? 12'd0 : cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 12'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/esc_pwm_generator.sv
// ESC servo pulse generator (1000us + 4us/count per frame), double-buffered; outputs registered, 1 cycle.
// No backpressure: value_valid is always accepted. Optional watchdog failsafe: ESC_WATCHDOG_EN.
module esc_pwm_generator
    import esc_pwm_generator_pkg::*;
#(
    parameter int FRAME_PERIOD_US = ESC_FRAME_PERIOD_US,
    parameter int MIN_PULSE_US    = ESC_MIN_PULSE_US,
    parameter int PULSE_SCALE     = ESC_PULSE_SCALE,
    parameter int MAX_VALUE       = ESC_MAX_VALUE
) (
    input  logic                         us_clk,
    input  logic                         resetn,
    input  logic [REC_VAL_BIT_WIDTH-1:0] throttle_pwm_value_in,
    input  logic                         value_valid,
    input  logic                         esc_enable_n,
    output logic                         pwm_out,
    output logic                         frame_start,
    output logic                         active_signal,
    output logic                         timeout_signal
);

    localparam logic [REC_VAL_BIT_WIDTH-1:0] MAX_V = REC_VAL_BIT_WIDTH'(MAX_VALUE);

    esc_state_e                   state_q, state_d;
    logic [REC_VAL_BIT_WIDTH-1:0] shadow_q, shadow_d;
    logic [REC_VAL_BIT_WIDTH-1:0] active_value_q, active_value_d;
    logic                         pwm_q, pwm_d;
    logic                         frame_start_q, frame_start_d;
    logic                         active_q, active_d;

    logic [REC_VAL_BIT_WIDTH-1:0] clamped;
    logic [11:0]                  frame_cnt;
    logic [11:0]                  width_m1;
    logic                         frame_tick;
    logic                         frame_tc;
    logic                         timer_clr;
    logic                         timer_en;

    assign clamped   = (throttle_pwm_value_in > MAX_V) ? MAX_V : throttle_pwm_value_in;
    assign timer_clr = esc_enable_n || (state_q == STATE_DISARMED);
    assign timer_en  = (state_q != STATE_DISARMED);
    // Stale in frame cycle 0 (active_value loads at its end), harmless since width-1 >= 999.
    assign width_m1  = pulse_width(active_value_q, MIN_PULSE_US, PULSE_SCALE) - 12'd1;

    esc_pwm_generator_frame_timer #(
        .PERIOD (FRAME_PERIOD_US)
    ) u_frame_timer (
        .clk_i   (us_clk),
        .rst_ni  (resetn),
        .clr_i   (timer_clr),
        .en_i    (timer_en),
        .cnt_o   (frame_cnt),
        .start_o (frame_tick),
        .tc_o    (frame_tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STATE_DISARMED:   if (!esc_enable_n) state_d = STATE_PULSE_HIGH;
            STATE_PULSE_HIGH: if (frame_cnt == width_m1) state_d = STATE_PULSE_LOW;
            STATE_PULSE_LOW:  if (frame_tc) state_d = STATE_PULSE_HIGH;
            default:          state_d = STATE_DISARMED;
        endcase
        if (esc_enable_n) state_d = STATE_DISARMED;

        pwm_d         = (state_d == STATE_PULSE_HIGH);
        active_d      = (state_d != STATE_DISARMED);
        frame_start_d = !esc_enable_n &&
                        ((state_q == STATE_DISARMED) || ((state_q == STATE_PULSE_LOW) && frame_tc));
    end

`ifdef ESC_WATCHDOG_EN
    logic [3:0] wd_q, wd_d;
    logic       seen_q, seen_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        wd_d = wd_q;
        if (esc_enable_n || value_valid) begin
            wd_d = 4'd0;
        end else if (frame_tick && !seen_q && (wd_q < 4'(ESC_WATCHDOG_FRAMES))) begin
            wd_d = wd_q + 4'd1;
        end
        // A strobe in the boundary cycle belongs to this frame, not the next window.
        seen_d    = frame_tick ? 1'b0 : (seen_q || value_valid);
        timeout_d = (wd_d >= 4'(ESC_WATCHDOG_FRAMES));
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            wd_q      <= 4'd0;
            seen_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            seen_q    <= seen_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_signal = timeout_q;
`else
    assign timeout_signal = 1'b0;
`endif

    always_comb begin
        shadow_d       = value_valid ? clamped : shadow_q;
        active_value_d = active_value_q;
        if (frame_tick) active_value_d = value_valid ? clamped : shadow_q;
`ifdef ESC_WATCHDOG_EN
        if (frame_tick && timeout_d) active_value_d = '0;
`endif
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= STATE_DISARMED;
            shadow_q       <= '0;
            active_value_q <= '0;
            pwm_q          <= 1'b0;
            frame_start_q  <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            active_value_q <= active_value_d;
            pwm_q          <= pwm_d;
            frame_start_q  <= frame_start_d;
            active_q       <= active_d;
        end
    end

    assign pwm_out       = pwm_q;
    assign frame_start   = frame_start_q;
    assign active_signal = active_q;

endmodule

// File: tb/tb_esc_pwm_generator.sv
// Directed bench for esc_pwm_generator: per-cycle frame-position model plus literal pulse-width pins.
module tb_esc_pwm_generator;

    logic       us_clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] throttle_pwm_value_in = 8'd0;
    logic       value_valid = 1'b0;
    logic       esc_enable_n = 1'b1;
    logic       pwm_out, frame_start, active_signal, timeout_signal;

    always #5 us_clk = ~us_clk;

    esc_pwm_generator dut (
        .us_clk                (us_clk),
        .resetn                (resetn),
        .throttle_pwm_value_in (throttle_pwm_value_in),
        .value_valid           (value_valid),
        .esc_enable_n          (esc_enable_n),
        .pwm_out               (pwm_out),
        .frame_start           (frame_start),
        .active_signal         (active_signal),
        .timeout_signal        (timeout_signal)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Model: frame position and width of the frame in progress.
    bit armed_m, seen_m, en_cur;
    int pos_m, width_m, shadow_m, wd_m;
    bit e_pwm, e_fs, e_act, e_to;
    bit prev_pwm;
    int hi_run, last_hi, fs_gap, last_per;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, got, exp);
    endtask

    task automatic model_reset();
        armed_m = 0; seen_m = 0; pos_m = 0; width_m = 1000; shadow_m = 0; wd_m = 0;
        e_pwm = 0; e_fs = 0; e_act = 0; e_to = 0;
        prev_pwm = 0; hi_run = 0; fs_gap = 0;
    endtask

    task automatic step(input bit vv, input int val, input bit en_n);
        int  cl;
        bit  boundary;
        check("outputs{pwm,fs,act,to}",
              int'({pwm_out, frame_start, active_signal, timeout_signal}),
              int'({e_pwm, e_fs, e_act, e_to}));
        if (e_pwm) hi_run++;
        else begin
            if (prev_pwm) last_hi = hi_run;
            hi_run = 0;
        end
        prev_pwm = e_pwm;
        if (e_fs) begin last_per = fs_gap; fs_gap = 1; end
        else fs_gap++;

        value_valid = vv;
        throttle_pwm_value_in = val[7:0];
        esc_enable_n = en_n;

        cl = (val > 250) ? 250 : val;
        boundary = armed_m && (pos_m == 0);
`ifdef ESC_WATCHDOG_EN
        if (en_n || vv) wd_m = 0;
        else if (boundary && !seen_m && wd_m < 8) wd_m++;
        seen_m = boundary ? 1'b0 : (seen_m | vv);
`endif
        if (boundary) width_m = 1000 + 4 * ((wd_m >= 8) ? 0 : (vv ? cl : shadow_m));
        if (vv) shadow_m = cl;
        if (en_n) begin armed_m = 0; pos_m = 0; end
        else if (!armed_m) begin armed_m = 1; pos_m = 0; end
        else pos_m = (pos_m + 1) % 2500;
        e_pwm = armed_m && (pos_m < width_m);
        e_fs  = armed_m && (pos_m == 0);
        e_act = armed_m;
        e_to  = (wd_m >= 8);
        @(negedge us_clk);
        cyc++;
    endtask

    task automatic run_to(input int p);
        int guard = 0;
        do begin
            step(1'b0, 0, en_cur);
            guard++;
        end while (!(armed_m && pos_m == p) && guard < 6000);
        if (guard >= 6000) begin
            n_total++;
            $display("FAIL run_to: frame position %0d not reached", p);
        end
    endtask

    task automatic frame_after(input int val, input int exp_width);
        step(1'b1, val, 1'b0);
        run_to(0);
        run_to(2100);
        check($sformatf("pulse width for value %0d", val), last_hi, exp_width);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        model_reset();
        last_hi = 0; last_per = 0;
        en_cur = 1;
        repeat (3) @(negedge us_clk);
        check("reset outputs", int'({pwm_out, frame_start, active_signal, timeout_signal}), 0);
        resetn = 1'b1;
        repeat (4) step(1'b0, 0, 1'b1);
        check("disarmed pwm", int'(pwm_out), 0);

        // Value captured while disarmed, then arm.
        step(1'b1, 125, 1'b1);
        en_cur = 0;
        run_to(0);
        check("arm frame_start", int'(frame_start), 1);
        run_to(0);
        run_to(1600);
        check("pulse width 125", last_hi, 1500);
        check("frame period", last_per, 2500);

        // Clamp and extremes.
        frame_after(255, 2000);
        frame_after(0, 1000);
        frame_after(250, 2000);
        frame_after(100, 1400);

        // Mid-frame strobe waits for next frame; cycle-0 strobe applies at once.
        run_to(1200);
        step(1'b1, 50, 1'b0);
        run_to(2100);
        check("width unchanged mid-frame", last_hi, 1400);
        run_to(0);
        run_to(2100);
        check("width after mid-frame strobe", last_hi, 1200);
        run_to(0);
        step(1'b1, 200, 1'b0);
        run_to(2100);
        check("cycle-0 strobe same frame", last_hi, 1800);

        // Disarm mid-pulse, then re-arm.
        run_to(0);
        run_to(600);
        en_cur = 1;
        step(1'b0, 0, 1'b1);
        check("disarm pwm low", int'(pwm_out), 0);
        check("disarm active low", int'(active_signal), 0);
        repeat (20) step(1'b0, 0, 1'b1);
        check("truncated pulse", last_hi, 601);
        en_cur = 0;
        step(1'b0, 0, 1'b0);
        check("rearm frame_start", int'(frame_start), 1);
        check("rearm pwm", int'(pwm_out), 1);
        run_to(2100);
        check("rearm full pulse", last_hi, 1800);

        // Asynchronous reset mid-pulse.
        run_to(0);
        run_to(500);
        #2;
        resetn = 1'b0;
        esc_enable_n = 1'b1;
        value_valid = 1'b0;
        #1;
        check("async reset pwm", int'(pwm_out), 0);
        @(negedge us_clk);
        @(negedge us_clk);
        model_reset();
        en_cur = 1;
        resetn = 1'b1;
        repeat (5) step(1'b0, 0, 1'b1);
        check("post-reset outputs", int'({pwm_out, frame_start, active_signal, timeout_signal}), 0);
        en_cur = 0;
        run_to(0);
        run_to(2100);
        check("post-reset shadow width", last_hi, 1000);

`ifdef ESC_WATCHDOG_EN
        step(1'b1, 200, 1'b0);
        for (int f = 0; f < 8; f++) begin
            run_to(0);
            run_to(2100);
            check("watchdog pre-timeout width", last_hi, 1800);
        end
        check("timeout not yet", int'(timeout_signal), 0);
        run_to(0);
        run_to(2100);
        check("failsafe width", last_hi, 1000);
        check("timeout set", int'(timeout_signal), 1);
        step(1'b1, 80, 1'b0);
        check("timeout cleared", int'(timeout_signal), 0);
        run_to(0);
        run_to(2100);
        check("width after recovery", last_hi, 1320);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/esc_pwm_generator.md
Name: esc_pwm_generator

Overview:
- Converts the 8-bit processed throttle value from the throttle controller into a standard ESC servo pulse on one motor pin.
- Pulse width is 1000 us + 4 us per count, inside a fixed-period frame.
- Sits between the throttle/mixer path and the board's motor pins; one instance per motor.
- New values are double-buffered so a pulse is never cut or stretched mid-frame.

Parameters:
- FRAME_PERIOD_US, 2500: frame length in us_clk cycles (400 Hz); legal range 2100..4095.
- MIN_PULSE_US, 1000: pulse width for value 0.
- PULSE_SCALE, 4: us of pulse per value count.
- MAX_VALUE, 250: input clamp ceiling, giving a maximum pulse of 2000 us.
- WATCHDOG_FRAMES, 8: frames without an update before failsafe (only used with the optional feature).

Ports:
- us_clk  input  1  1 MHz system microsecond clock.
- resetn  input  1  asynchronous active-low reset.
- throttle_pwm_value_in  input  `REC_VAL_BIT_WIDTH  new throttle value.
- value_valid  input  1  one-cycle strobe qualifying throttle_pwm_value_in (driven by the controller's complete_signal).
- esc_enable_n  input  1  active-low arm; high = disarmed.
- pwm_out  output  1  ESC pulse pin, registered.
- frame_start  output  1  one-cycle strobe in the first cycle of each frame.
- active_signal  output  1  high while armed and generating frames.
- timeout_signal  output  1  watchdog failsafe indicator.

Behaviour:
- Clock and reset: one clock, us_clk. Reset is asynchronous and active-low on resetn.
- Reset values: pwm_out=0, frame_start=0, active_signal=0, timeout_signal=0, shadow_value=0, active_value=0, frame counter=0, state=STATE_DISARMED.
- Input capture: on value_valid, shadow_value <= min(throttle_pwm_value_in, MAX_VALUE). Values 251..255 become 250.
- Capture is accepted in every state, including disarmed. A later strobe overwrites an earlier one within the same frame; last write wins.
- Width: active width = MIN_PULSE_US + PULSE_SCALE*active_value, computed at 12 bits unsigned. The maximum is 2000, so no overflow.
- State STATE_DISARMED:
  - pwm_out=0, counter held at 0, active_signal=0.
  - When esc_enable_n==0, go to STATE_PULSE_HIGH on the next cycle. That cycle is frame cycle 0.
- Frame cycle 0 (frame boundary):
  - active_value <= shadow_value.
  - frame_start=1 for this cycle only.
  - pwm_out=1.
  - If value_valid occurs in the same cycle as the boundary, the new value bypasses the shadow and is used for this frame.
- State STATE_PULSE_HIGH: pwm_out=1 for exactly the active width in cycles (counter 0..width-1), then go to STATE_PULSE_LOW.
- State STATE_PULSE_LOW: pwm_out=0 until counter==FRAME_PERIOD_US-1. The counter then wraps to 0 and the state returns to STATE_PULSE_HIGH. The frame is exactly FRAME_PERIOD_US cycles.
- Update latency: a value strobed at any point in frame N is output in frame N+1. A value strobed in cycle 0 of frame N is output in frame N.
- Disarm: esc_enable_n=1 in any state forces STATE_DISARMED on the next edge, with pwm_out=0 immediately (registered, one cycle), even mid-pulse. A truncated pulse is accepted on disarm only.
- Re-arm: always starts a fresh full frame.
- Reset mid-pulse: pwm_out drops to 0 asynchronously.

Optional Feature:
- Macro: ESC_WATCHDOG_EN.
- With the macro defined:
  - A 4-bit frame counter increments at each frame boundary that has had no value_valid since the previous boundary.
  - When it reaches WATCHDOG_FRAMES, timeout_signal=1 and active_value is forced to 0 (1000 us pulses) at each boundary.
  - Any value_valid clears the counter and timeout_signal; the new value applies at the next boundary.
  - Disarm also clears the counter.
- Without the macro: timeout_signal is tied 0 and the last value is held indefinitely.

Decomposition:
- Add to common_defines.v:
  - ESC_FRAME_PERIOD_US, ESC_MIN_PULSE_US, ESC_PULSE_SCALE, ESC_MAX_VALUE.
  - The 3-state one-hot encodings.
- Sub-module esc_frame_timer: 12-bit frame counter with clear/enable, producing frame_start and terminal-count strobes. The parent holds the FSM, the shadow/active registers and the watchdog.

Test Plan:
1. Reset, esc_enable_n=0, strobe value 125 before the first boundary -> frame_start every 2500 cycles, pwm_out high exactly 1500 cycles per frame.
2. Strobe 255 -> 2000-cycle pulse. Strobe 0 -> 1000-cycle pulse. Strobe 250 -> 2000-cycle pulse.
3. Strobe 50 at frame cycle 1200 while outputting 100 -> current frame pulse 1400 cycles, next frame 1200 cycles. Strobe in cycle 0 -> applied in the same frame.
4. Raise esc_enable_n at cycle 600 of a 1800-cycle pulse -> pwm_out low the next cycle, active_signal=0, no frame_start. Re-arm -> full frame starts next cycle.
5. With ESC_WATCHDOG_EN, value 200 then no strobes -> 8 frames at 1800, then timeout_signal=1 and 1000-cycle pulses. One strobe of 80 -> timeout clears, next frame 1320.
6. Assert resetn low mid-pulse -> pwm_out=0 immediately. After release, outputs are at reset values and the block is disarmed until the arm condition is evaluated.
